// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared encodings and types for the fetch stage.
// Holds FSM states, the reset PC default and the IR bundle.
package ifu_fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ir_t;

   function automatic logic [31:0] word_align(
      input logic [31:0] a
   );
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_fetch_pc_unit.sv
// ifu_fetch_pc_unit: program counter register.
// Reset load, +4 advance, aligned redirect load.
module ifu_fetch_pc_unit
   import ifu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        advance,
   output logic [31:0] pc
);

   // Redirect wins over sequential advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= word_align(redirect_pc);
      end else if (advance) begin
         pc <= pc + 32'd4;
      end
   end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch stage.
// Owns the fetch FSM, the discard flag and the instruction register.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc4,
   output logic [31:0] out_instr,
   output logic [15:0] out_imm16
);

   fetch_state_t state;
   logic         discard;
   logic         valid_q;
   ir_t          ir;
   logic [31:0]  pc;
   logic         advance;
   logic         drop_rsp;

   // Sequential advance only when decode takes the held instruction.
   assign advance = (state == HOLD) & out_ready & ~redirect_valid;

   // A response is stale if redirected before or during its arrival.
   assign drop_rsp = discard | redirect_valid;

   ifu_fetch_pc_unit #(
      .RESET_PC(RESET_PC)
   ) u_pc_unit (
      .clk           (clk),
      .rst           (rst),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .advance       (advance),
      .pc            (pc)
   );

   // Fetch control: request, wait for data, hold for decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= FETCH;
         discard <= 1'b0;
         valid_q <= 1'b0;
         ir      <= '{pc: RESET_PC, instr: 32'd0};
      end else begin
         unique case (state)
            FETCH: begin
               state <= WAIT;
               if (redirect_valid) begin
                  discard <= 1'b1;
               end
            end
            WAIT: begin
               unique case (1'b1)
                  imem_rvalid & drop_rsp: begin
                     discard <= 1'b0;
                     state   <= FETCH;
                  end
                  imem_rvalid & ~drop_rsp: begin
                     state   <= HOLD;
                     valid_q <= 1'b1;
                     ir      <= '{pc: pc, instr: imem_rdata};
                  end
                  ~imem_rvalid & redirect_valid: begin
                     discard <= 1'b1;
                  end
                  default: begin
                  end
               endcase
            end
            HOLD: begin
               if (redirect_valid | out_ready) begin
                  state   <= FETCH;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state   <= FETCH;
               discard <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req  = (state == FETCH) & ~rst;
   assign imem_addr = pc;
   assign out_valid = valid_q;
   assign out_pc    = ir.pc;
   assign out_instr = ir.instr;
   assign out_pc4   = ir.pc + 32'd4;
   assign out_imm16 = ir.instr[15:0];

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed vector table plus randomized run
// against a transaction-level model of the fetch stage.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_pc4;
   logic [31:0] out_instr;
   logic [15:0] out_imm16;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ifu_fetch #(
      .RESET_PC(32'h0000_3000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_pc4       (out_pc4),
      .out_instr     (out_instr),
      .out_imm16     (out_imm16)
   );

   // Memory must only answer while the stage is waiting.
   always @(posedge clk) begin
      if (!rst && imem_rvalid) begin
         assert (!imem_req && !out_valid)
         else $error("FAIL rvalid_protocol: req=%0b valid=%0b",
                     imem_req, out_valid);
      end
   end

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
   endfunction

   typedef struct {
      logic        rs;
      logic        rv;
      logic [31:0] rd;
      logic        rdy;
      logic        rdr;
      logic [31:0] rp;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic        e_chk;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(
      logic rs, logic rv, logic [31:0] rd,
      logic rdy, logic rdr, logic [31:0] rp,
      logic er, logic [31:0] ea,
      logic ev, logic ec,
      logic [31:0] ep, logic [31:0] ei);
      vec_t t;
      t.rs = rs; t.rv = rv; t.rd = rd;
      t.rdy = rdy; t.rdr = rdr; t.rp = rp;
      t.e_req = er; t.e_addr = ea;
      t.e_valid = ev; t.e_chk = ec;
      t.e_pc = ep; t.e_instr = ei;
      return t;
   endfunction

   task automatic check_ir(input string tag,
                           input logic [31:0] pc_e,
                           input logic [31:0] in_e);
      logic [15:0] imm_e;
      imm_e = in_e[15:0];
      check({tag, "_pc"}, out_pc, pc_e);
      check({tag, "_instr"}, out_instr, in_e);
      check({tag, "_pc4"}, out_pc4, pc_e + 32'd4);
      check({tag, "_imm16"}, {16'd0, out_imm16}, {16'd0, imm_e});
   endtask

   // Random-phase model state
   logic [31:0] next_addr;
   logic [31:0] cur_addr;
   logic        outstanding;
   logic        tainted;
   int          cnt;
   logic        m_valid;
   logic [31:0] m_pc;
   logic [31:0] m_instr;

   initial begin
      logic        e_req;
      logic        rv;
      logic        rdy;
      logic        rdr;
      logic [31:0] tgt;

      rst = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata = 32'd0;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      out_ready = 1'b0;

      // rs rv rd rdy rdr rp | req addr valid chk pc instr
      tbl.push_back(v(1,0,0,0,0,0, 0,0,0,1,32'h3000,0));
      tbl.push_back(v(0,0,0,1,0,0, 1,32'h3000,0,0,0,0));
      tbl.push_back(v(0,1,32'h3C01_1234,1,0,0, 0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,1,0,0,
                      0,0,1,0,32'h3000,32'h3C01_1234));
      tbl.push_back(v(0,0,0,1,0,0, 1,32'h3004,0,0,0,0));
      tbl.push_back(v(0,1,32'h3C01_1234,0,0,0, 0,0,0,0,0,0));
      for (int k = 0; k < 5; k++)
         tbl.push_back(v(0,0,0,0,0,0,
                         0,0,1,0,32'h3004,32'h3C01_1234));
      tbl.push_back(v(0,0,0,1,0,0,
                      0,0,1,0,32'h3004,32'h3C01_1234));
      tbl.push_back(v(0,0,0,1,0,0, 1,32'h3008,0,0,0,0));
      tbl.push_back(v(0,0,0,0,1,32'h0000_4003, 0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(v(0,1,32'hDEAD_BEEF,1,0,0, 0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,1,0,0, 1,32'h4000,0,0,0,0));
      tbl.push_back(v(0,1,32'h1111_1111,1,1,32'h5000,
                      0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,1,0,0, 1,32'h5000,0,0,0,0));
      tbl.push_back(v(0,1,32'h2222_0000,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,1,1,32'hFFFF_FFFC,
                      0,0,1,0,32'h5000,32'h2222_0000));
      tbl.push_back(v(0,0,0,0,0,0, 1,32'hFFFF_FFFC,0,0,0,0));
      tbl.push_back(v(0,1,32'h3333_4444,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,1,0,0,
                      0,0,1,0,32'hFFFF_FFFC,32'h3333_4444));
      tbl.push_back(v(0,0,0,0,0,0, 1,32'h0000_0000,0,0,0,0));
      tbl.push_back(v(1,0,0,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(v(1,0,0,0,0,0, 0,0,0,1,32'h3000,0));
      tbl.push_back(v(0,0,0,0,0,0, 1,32'h3000,0,0,0,0));
      tbl.push_back(v(0,1,32'h4444_5555,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,1,0,0,
                      0,0,1,0,32'h3000,32'h4444_5555));

      @(posedge clk);
      foreach (tbl[i]) begin
         @(negedge clk);
         rst = tbl[i].rs;
         imem_rvalid = tbl[i].rv;
         imem_rdata = tbl[i].rd;
         out_ready = tbl[i].rdy;
         redirect_valid = tbl[i].rdr;
         redirect_pc = tbl[i].rp;
         #1;
         check($sformatf("t%0d_req", i), {31'd0, imem_req},
               {31'd0, tbl[i].e_req});
         if (tbl[i].e_req)
            check($sformatf("t%0d_addr", i), imem_addr,
                  tbl[i].e_addr);
         check($sformatf("t%0d_valid", i), {31'd0, out_valid},
               {31'd0, tbl[i].e_valid});
         if (tbl[i].e_valid || tbl[i].e_chk)
            check_ir($sformatf("t%0d", i), tbl[i].e_pc,
                     tbl[i].e_instr);
      end

      // Randomized run against the transaction model.
      @(negedge clk);
      rst = 1'b1;
      imem_rvalid = 1'b0;
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      next_addr = 32'h0000_3000;
      cur_addr = 32'd0;
      outstanding = 1'b0;
      tainted = 1'b0;
      cnt = 0;
      m_valid = 1'b0;
      m_pc = 32'd0;
      m_instr = 32'd0;

      for (int c = 0; c < 3000; c++) begin
         #1;
         e_req = !outstanding && !m_valid;
         check("rnd_req", {31'd0, imem_req}, {31'd0, e_req});
         if (e_req)
            check("rnd_addr", imem_addr, next_addr);
         check("rnd_valid", {31'd0, out_valid}, {31'd0, m_valid});
         if (m_valid)
            check_ir("rnd", m_pc, m_instr);

         rv = 1'b0;
         if (outstanding) begin
            cnt--;
            if (cnt == 0) rv = 1'b1;
         end
         rdy = 1'($urandom_range(0, 1));
         rdr = ($urandom_range(0, 7) == 0);
         tgt = $urandom;
         if ($urandom_range(0, 3) == 0)
            tgt = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));

         imem_rvalid = rv;
         imem_rdata = rv ? mem(cur_addr) : $urandom;
         out_ready = rdy;
         redirect_valid = rdr;
         redirect_pc = tgt;

         if (m_valid) begin
            if (rdr) begin
               m_valid = 1'b0;
            end else if (rdy) begin
               m_valid = 1'b0;
               next_addr = m_pc + 32'd4;
            end
         end
         if (e_req) begin
            outstanding = 1'b1;
            tainted = rdr;
            cnt = $urandom_range(1, 4);
            cur_addr = next_addr;
         end else if (outstanding) begin
            if (rv) begin
               outstanding = 1'b0;
               if (!(tainted || rdr)) begin
                  m_valid = 1'b1;
                  m_pc = cur_addr;
                  m_instr = mem(cur_addr);
               end
            end else if (rdr) begin
               tainted = 1'b1;
            end
         end
         if (rdr)
            next_addr = {tgt[31:2], 2'b00};

         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
